// File: rtl/video_pkg.sv
// Shared types and timing helpers for the raster generator.
// Regions on each axis are ordered active, front porch, sync, back porch.
package video_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  typedef struct packed {
    int total;
    int sync_start;
    int sync_end;
  } bounds_t;

  function automatic bounds_t calc_bounds(input timing_t t);
    bounds_t b;
    b.total      = t.active + t.fp + t.sync + t.bp;
    b.sync_start = t.active + t.fp;
    b.sync_end   = t.active + t.fp + t.sync;
    return b;
  endfunction

endpackage

// File: rtl/video_counter.sv
// Wrapping counter 0..MAX-1 with hold-at-zero clear and terminal-count flag.
// Latency: value updates one clock after en; tc is combinational from value.
// Backpressure: none; en simply gates the count.
module video_counter #(
  parameter int MAX = 8,
  parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic         tc,
  output logic [W-1:0] value
);

  assign tc = (value == W'(MAX - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (en) begin
      value <= tc ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with pixel pull, underflow fill and 36-bit packing.
// Latency: all HDMI_* outputs, frame_start and underflow lag the counters by 1 clock.
// Backpressure: the raster never stalls; a missing pixel is sent as black and flagged.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE   = 720,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 62,
  parameter int   H_BP       = 60,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 9,
  parameter int   V_SYNC     = 6,
  parameter int   V_BP       = 30,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   COMP_W     = 8,
  parameter int   OUT_COMP_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [3*COMP_W-1:0]     pix_data,
  input  logic                    pix_valid,
  output logic                    pix_rdy,
  input  logic                    underflow_clr,
  output logic [3*OUT_COMP_W-1:0] HDMI_DATA,
  output logic                    HDMI_HSYNC,
  output logic                    HDMI_VSYNC,
  output logic                    HDMI_EN,
  output logic                    frame_start,
  output logic                    underflow,
  output logic                    busy
);

  localparam timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam bounds_t H_B = calc_bounds(H_T);
  localparam bounds_t V_B = calc_bounds(V_T);
  localparam int HW = $clog2(H_B.total);
  localparam int VW = $clog2(V_B.total);

  state_t          state, state_nxt;
  logic [HW-1:0]   h;
  logic [VW-1:0]   v;
  logic            h_tc, v_tc, running;
  logic            h_act, v_act, hs_on, vs_on;
  logic [3*OUT_COMP_W-1:0] packed_pix;

  assign running = (state != IDLE);
  assign busy    = running;

  video_counter #(.MAX(H_B.total), .W(HW)) u_hcnt (
    .clk(clk), .rst(rst), .en(running), .clr(!running), .tc(h_tc), .value(h)
  );

  video_counter #(.MAX(V_B.total), .W(VW)) u_vcnt (
    .clk(clk), .rst(rst), .en(running && h_tc), .clr(!running), .tc(v_tc), .value(v)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A re-raised run wins even on the last cycle so the frame period has no gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = ACTIVE;
      ACTIVE:  if (!run) state_nxt = DRAIN;
      DRAIN: begin
        if (run)               state_nxt = ACTIVE;
        else if (h_tc && v_tc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    h_act = int'(h) < H_B.sync_start - H_FP;
    v_act = int'(v) < V_B.sync_start - V_FP;
    hs_on = running && (int'(h) >= H_B.sync_start) && (int'(h) < H_B.sync_end);
    vs_on = running && (int'(v) >= V_B.sync_start) && (int'(v) < V_B.sync_end);
  end

  assign pix_rdy = running && h_act && v_act;

  // Left-align each component; R ends up in the MSBs because pix_data is {R,G,B}.
  always_comb begin
    packed_pix = '0;
    for (int i = 0; i < 3; i++) begin
      packed_pix[i*OUT_COMP_W +: OUT_COMP_W] =
        OUT_COMP_W'(pix_data[i*COMP_W +: COMP_W]) << (OUT_COMP_W - COMP_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      HDMI_DATA   <= '0;
      HDMI_EN     <= 1'b0;
      HDMI_HSYNC  <= ~HS_POL;
      HDMI_VSYNC  <= ~VS_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      HDMI_DATA   <= (pix_rdy && pix_valid) ? packed_pix : '0;
      HDMI_EN     <= pix_rdy;
      HDMI_HSYNC  <= hs_on ? HS_POL : ~HS_POL;
      HDMI_VSYNC  <= vs_on ? VS_POL : ~VS_POL;
      frame_start <= running && (h == '0) && (v == '0);
      underflow   <= (pix_rdy && !pix_valid) || (underflow && !underflow_clr);
    end
  end

endmodule
